pipelined_rca_adder: RTL

PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

---
 rtl/pipelined_rca_adder_if.sv | 24 ++
 rtl/pipelined_rca_adder.sv | 65 ++++++
 2 files changed

// File: rtl/pipelined_rca_adder_if.sv
// pipelined_rca_adder_if: valid/ready operand and result bundle for pipelined_rca_adder.
interface pipelined_rca_adder_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             ovf;
   modport master (
      output in_valid, in1, in2, cin, sub, out_ready,
      input  in_ready, out_valid, out, cout, ovf
   );
   modport slave (
      input  in_valid, in1, in2, cin, sub, out_ready,
      output in_ready, out_valid, out, cout, ovf
   );
endinterface

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder: STAGES-deep ripple-carry add/subtract, one SLICE per stage, valid/ready with whole-pipe stall.
module pipelined_rca_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_rca_adder_if.slave bus
);
   localparam int SLICE = WIDTH / STAGES;
   logic                          stall;
   logic [STAGES-1:0]             vld_q, vld_d, c_q, c_d, c_in;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d, s_in;
   logic [SLICE:0]                t;
   assign stall         = vld_q[STAGES-1] && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.out       = s_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                          (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
   // Operand B is stored already inverted for subtract, so the final stage sees B' directly for overflow.
   always_comb begin
      vld_d   = '0;
      a_d     = '0;
      b_d     = '0;
      c_in    = '0;
      s_in    = '0;
      s_d     = '0;
      c_d     = '0;
      t       = '0;
      vld_d[0] = bus.in_valid;
      a_d[0]   = bus.in1;
      b_d[0]   = bus.sub ? ~bus.in2 : bus.in2;
      c_in[0]  = bus.sub || bus.cin;
      for (int k = 1; k < STAGES; k++) begin
         vld_d[k] = vld_q[k-1];
         a_d[k]   = a_q[k-1];
         b_d[k]   = b_q[k-1];
         c_in[k]  = c_q[k-1];
         s_in[k]  = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         t = {1'b0, a_d[k][k*SLICE +: SLICE]} + {1'b0, b_d[k][k*SLICE +: SLICE]} + (SLICE+1)'(c_in[k]);
         s_d[k] = s_in[k];
         s_d[k][k*SLICE +: SLICE] = t[SLICE-1:0];
         c_d[k] = t[SLICE];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         c_q   <= '0;
      end else if (!stall) begin
         vld_q <= vld_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         c_q   <= c_d;
      end
   end
endmodule
